mem_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the core's fetch port (I) and load/store port (D). It sits between the CPU and the memory inside `soc` and allows one transaction in flight at a time. It serialises contending requests, drives the memory for one issue cycle, and counts out the fixed memory read latency. It then returns a registered read response to the requester that owns the transaction.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (I) and load/store (D), one transaction in flight.
// Define ARB_RR_EN for round-robin on contention; the default build gives D fixed priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int         STRB_W = DATA_W / 8;
    localparam logic [3:0] LAT    = 4'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                owner_d_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;
    logic                pick_d;

`ifdef ARB_RR_EN
    logic last_d_q;
    // On contention the port that did not own the previous grant wins.
    assign pick_d = d_req && (!i_req || !last_d_q);
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req || d_req) state_d = ISSUE;
            ISSUE:   state_d = we_q ? IDLE : WAIT;
            WAIT:    if (cnt_q == LAT) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_d_q <= 1'b0;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_RR_EN
            last_d_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_d_q <= pick_d;
                        addr_q    <= pick_d ? d_addr : i_addr;
                        we_q      <= pick_d && d_we;
                        wdata_q   <= pick_d ? d_wdata : '0;
                        wstrb_q   <= pick_d ? d_wstrb : '0;
                    end
                end
                ISSUE: begin
`ifdef ARB_RR_EN
                    last_d_q <= owner_d_q;
`endif
                    if (!we_q) cnt_q <= 4'd1;
                end
                WAIT: begin
                    if (cnt_q == LAT) begin
                        if (owner_d_q) d_rdata_q <= mem_rdata;
                        else           i_rdata_q <= mem_rdata;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = (state_q == ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign i_gnt     = (state_q == ISSUE) && !owner_d_q;
    assign d_gnt     = (state_q == ISSUE) &&  owner_d_q;
    assign i_rvalid  = (state_q == RESP)  && !owner_d_q;
    assign d_rvalid  = (state_q == RESP)  &&  owner_d_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/responses queued at drive time, popped on DUT output.
module tb_mem_arbiter;
    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory image and latency model
    logic [31:0] img [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (img.exists(a)) return img[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    logic        rd_active = 1'b0;
    int          rd_rem = 0;
    logic [31:0] rd_data = '0;
    logic [31:0] junk = 32'h5555_AAAA;

    always @(posedge clk) begin
        junk <= $urandom;
        if (mem_en && !mem_we) begin
            rd_active <= 1'b1;
            rd_rem    <= MEM_LAT - 1;
            rd_data   <= mem_read(mem_addr);
        end else if (rd_active && rd_rem != 0) begin
            rd_rem <= rd_rem - 1;
        end else begin
            rd_active <= 1'b0;
        end
    end
    assign mem_rdata = (rd_active && rd_rem == 0) ? rd_data : junk;

    typedef struct {
        bit          d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } gnt_t;
    typedef struct {
        bit          d;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    gnt_t g;
    rsp_t r;
    logic [31:0] wv;

    // Monitor: grants and responses popped against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en !== (i_gnt | d_gnt)) check("en_vs_gnt", mem_en, i_gnt | d_gnt);
            if (i_gnt && d_gnt) begin
                check("dual_gnt", 1, 0);
            end else if (i_gnt || d_gnt) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexp", 1, 0);
                end else begin
                    g = gnt_q.pop_front();
                    check("gnt_port", d_gnt, g.d);
                    check("gnt_cyc", cyc, g.cyc);
                    check("mem_addr", mem_addr, g.addr);
                    check("mem_we", mem_we, g.we);
                    if (g.we) begin
                        check("mem_wdata", mem_wdata, g.wdata);
                        check("mem_wstrb", mem_wstrb, g.wstrb);
                        wv = mem_read(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) wv[b*8 +: 8] = mem_wdata[b*8 +: 8];
                        img[mem_addr] = wv;
                    end
                end
            end
            if (i_rvalid && d_rvalid) begin
                check("dual_rvalid", 1, 0);
            end else if (i_rvalid || d_rvalid) begin
                if (rsp_q.size() == 0) begin
                    check("rvalid_unexp", 1, 0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_port", d_rvalid, r.d);
                    check("rsp_cyc", cyc, r.cyc);
                    check("rsp_data", r.d ? d_rdata : i_rdata, r.data);
                end
            end
        end
    end

    task automatic idle_wait();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic wait_gnt(input bit is_d);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (is_d ? d_gnt : i_gnt) return;
        end
        check("gnt_timeout", 0, 1);
    endtask

    task automatic fetch(input logic [31:0] a, input bit drop_early);
        idle_wait();
        i_req = 1'b1;
        i_addr = a;
        gnt_q.push_back('{d: 1'b0, we: 1'b0, addr: a, wdata: '0, wstrb: '0, cyc: cyc + 1});
        rsp_q.push_back('{d: 1'b0, data: mem_read(a), cyc: cyc + 2 + MEM_LAT});
        if (drop_early) begin
            @(negedge clk);
            i_req = 1'b0;
            i_addr = 32'hBAD0_0000;
        end else begin
            wait_gnt(1'b0);
            i_req = 1'b0;
        end
    endtask

    task automatic dmem(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        idle_wait();
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
        gnt_q.push_back('{d: 1'b1, we: we, addr: a, wdata: wd, wstrb: ws, cyc: cyc + 1});
        if (!we) rsp_q.push_back('{d: 1'b1, data: mem_read(a), cyc: cyc + 2 + MEM_LAT});
        wait_gnt(1'b1);
        d_req = 1'b0; d_we = 1'b0;
        if (we) begin
            @(negedge clk);
            check("st_busy_t2", busy, 0);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_i_gnt"}, i_gnt, 0);
        check({pfx, "_d_gnt"}, d_gnt, 0);
        check({pfx, "_i_rvalid"}, i_rvalid, 0);
        check({pfx, "_d_rvalid"}, d_rvalid, 0);
        check({pfx, "_mem_en"}, mem_en, 0);
        check({pfx, "_mem_we"}, mem_we, 0);
        check({pfx, "_mem_addr"}, mem_addr, 0);
        check({pfx, "_mem_wdata"}, mem_wdata, 0);
        check({pfx, "_mem_wstrb"}, mem_wstrb, 0);
        check({pfx, "_i_rdata"}, i_rdata, 0);
        check({pfx, "_d_rdata"}, d_rdata, 0);
        check({pfx, "_busy"}, busy, 0);
    endtask

    bit exp_d [4];
    int grants;
    int c0;

    initial begin
        img[32'h0000_0040] = 32'h0000_0013;
        img[32'h0000_2000] = 32'hA5A5_A5A5;

        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b0;

        fetch(32'h0000_0040, 1'b0);
        dmem(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
        dmem(1'b0, 32'h0000_2000, '0, '0);
        dmem(1'b0, 32'h0000_1000, '0, '0);
        dmem(1'b1, 32'h0000_1004, 32'h1234_5678, 4'b0000);
        dmem(1'b0, 32'h0000_1004, '0, '0);
        fetch(32'h0000_0044, 1'b1);
        fetch(32'h0000_2000, 1'b0);

        // Reset while a fetch sits in WAIT: the fetch is dropped entirely
        idle_wait();
        i_req = 1'b1;
        i_addr = 32'h0000_0080;
        gnt_q.push_back('{d: 1'b0, we: 1'b0, addr: 32'h80, wdata: '0, wstrb: '0, cyc: cyc + 1});
        wait_gnt(1'b0);
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_wait");
        rst = 1'b0;
        repeat (MEM_LAT + 6) @(negedge clk);
        check("rst_wait_busy_after", busy, 0);

        // Contention: both ports request continuously for four transactions
`ifdef ARB_RR_EN
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        idle_wait();
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
        c0 = cyc;
        begin
            int ni, nd;
            logic [31:0] a;
            ni = 0; nd = 0;
            for (int k = 0; k < 4; k++) begin
                a = exp_d[k] ? 32'h3000 + 32'(4 * nd) : 32'h100 + 32'(4 * ni);
                if (exp_d[k]) nd++; else ni++;
                gnt_q.push_back('{d: exp_d[k], we: 1'b0, addr: a, wdata: '0, wstrb: '0,
                                  cyc: c0 + 1 + k * (3 + MEM_LAT)});
                rsp_q.push_back('{d: exp_d[k], data: mem_read(a), cyc: c0 + 2 + MEM_LAT + k * (3 + MEM_LAT)});
            end
        end
        grants = 0;
        for (int i = 0; i < 200 && grants < 4; i++) begin
            @(negedge clk);
            if (i_gnt) begin grants++; i_addr = i_addr + 32'd4; end
            if (d_gnt) begin grants++; d_addr = d_addr + 32'd4; end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("contention_grants", grants, 4);

        for (int i = 0; i < 100 && (gnt_q.size() != 0 || rsp_q.size() != 0); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("gnt_q_drained", gnt_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
